bram1_result_streamer: RTL

- Downstream stage of the BRAM accessor. Once the accessor signals done, this block reads the result words from BRAM1 (port 1, read-only).
- Each DWIDTH_2 word holds four DWIDTH_2/4-bit lane results. The block sums the four lanes and emits one sum per word on a valid/ready stream.
- Also keeps a running total of all emitted sums for readback by the register block.
- Absorbs the 1-cycle BRAM read latency and downstream backpressure with a 2-entry buffer.

---
 rtl/bram1_result_streamer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bram1_result_streamer.sv
// bram1_result_streamer: reads N result words from BRAM1 once started, sums the
// four lanes of each word and streams one sum per word on a valid/ready port.
// A 2-entry buffer absorbs the 1-cycle BRAM read latency and downstream stalls;
// a running total of every handshaken sum is kept for register readback.
module bram1_result_streamer #(
  parameter int CNT_BIT  = 31,
  parameter int DWIDTH_2 = 64,
  parameter int AWIDTH   = 8,
  parameter int MEM_SIZE = 256,
  parameter int TOT_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start_run_i,
  input  logic [CNT_BIT-1:0]          run_count_i,
  output logic                        idle_o,
  output logic                        run_o,
  output logic                        done_o,
  output logic [AWIDTH-1:0]           addr_b1_o,
  output logic                        ce_b1_o,
  output logic                        we_b1_o,
  input  logic [DWIDTH_2-1:0]         q_b1_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [(DWIDTH_2/4)+1:0]     m_data_o,
  output logic                        m_last_o,
  output logic [TOT_W-1:0]            total_o
);

  localparam int LW = DWIDTH_2 / 4;
  localparam int SW = LW + 2;

  // The issued counter drives the address directly, so the memory must fit
  // inside the address space.
  if (MEM_SIZE > (1 << AWIDTH)) begin : g_mem_size_check
    $error("MEM_SIZE exceeds the BRAM1 address space");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_BIT-1:0] n_q;
  logic [CNT_BIT-1:0] issued_q;
  logic [CNT_BIT-1:0] popped_q;
  logic               vld_p1;     // read issued last cycle, data on q_b1_i now
  logic [1:0]         fill_q;
  logic [SW-1:0]      buf0_p2;    // head of the buffer
  logic [SW-1:0]      buf1_p2;
  logic [TOT_W-1:0]   total_q;
  logic [SW-1:0]      sum_p1;
  logic               pop;
  logic               ce;
  logic               last_beat;
  logic [2:0]         occ;

  // Zero-extended sum of the four LW-bit lanes; SW bits cannot overflow.
  function automatic logic [SW-1:0] lane_sum(input logic [DWIDTH_2-1:0] w);
    logic [SW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + SW'(w[i*LW +: LW]);
    end
    return acc;
  endfunction

  assign sum_p1 = lane_sum(q_b1_i);

  // Next-state, read-issue and handshake decode.
  always_comb begin
    state_d   = state_q;
    ce        = 1'b0;
    pop       = (fill_q != 2'd0) & m_ready_i;
    last_beat = (popped_q == (n_q - CNT_BIT'(1)));
    occ       = {1'b0, fill_q} + {2'b00, vld_p1};
    case (state_q)
      S_IDLE: begin
        if (start_run_i) begin
          state_d = (run_count_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Only issue when the buffer is guaranteed a free slot at capture.
        ce = (issued_q < n_q) && (occ <= ({2'b00, pop} + 3'd1));
        if (pop && last_beat) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, in-flight flag, buffer occupancy and running total.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      n_q      <= '0;
      issued_q <= '0;
      popped_q <= '0;
      vld_p1   <= 1'b0;
      fill_q   <= 2'd0;
      total_q  <= '0;
    end else begin
      vld_p1 <= ce;
      if ((state_q == S_IDLE) && start_run_i) begin
        n_q      <= run_count_i;
        issued_q <= '0;
        popped_q <= '0;
        total_q  <= '0;
      end else begin
        if (ce) begin
          issued_q <= issued_q + CNT_BIT'(1);
        end
        if (pop) begin
          popped_q <= popped_q + CNT_BIT'(1);
          total_q  <= total_q + TOT_W'(buf0_p2);
        end
      end
      case ({vld_p1, pop})
        2'b10:   fill_q <= fill_q + 2'd1;
        2'b01:   fill_q <= fill_q - 2'd1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Buffer data path: capture the lane sum one cycle after each issue.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      if (pop) begin
        if (fill_q == 2'd2) begin
          buf0_p2 <= buf1_p2;
          buf1_p2 <= sum_p1;
        end else begin
          buf0_p2 <= sum_p1;
        end
      end else if (fill_q == 2'd0) begin
        buf0_p2 <= sum_p1;
      end else begin
        buf1_p2 <= sum_p1;
      end
    end else if (pop) begin
      buf0_p2 <= buf1_p2;
    end
  end

  assign idle_o    = (state_q == S_IDLE);
  assign run_o     = (state_q == S_RUN);
  assign done_o    = (state_q == S_DONE);
  assign addr_b1_o = issued_q[AWIDTH-1:0];
  assign ce_b1_o   = ce;
  assign we_b1_o   = 1'b0;
  assign m_valid_o = (fill_q != 2'd0);
  assign m_data_o  = buf0_p2;
  assign m_last_o  = m_valid_o & last_beat;
  assign total_o   = total_q;

endmodule
